disp2_arbiter_ctrl: RTL and testbench
=====================================

DISP2_ARBITER_CTRL -- requirements
Module: disp2_arbiter_ctrl

Interface
REQ-001 Parameter BURST_MAX, default 4, SHALL set the max consecutive reads granted to one lane while the other lane is waiting; legal range 1..7.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 empty_f1, empty_f2  input  1 each  lane FIFO empty flags, combinational from the FIFOs.
REQ-005 almost_full_f1, almost_full_f2  input  1 each  lane FIFO almost-full flags.
REQ-006 data_f1, data_f2  input  8 each  lane FIFO read data, valid the cycle after the matching read.
REQ-007 pause  input  1  downstream not-ready; no read is issued while it is high.
REQ-008 read_f1, read_f2  output  1 each  FIFO read strobes, one pop per high cycle.
REQ-009 write  output  1  upstream write enable for both lane FIFOs.
REQ-010 data_out  output  8  drained byte.
REQ-011 valid_out  output  1  data_out qualifier, one cycle per byte.
REQ-012 grant  output  2  one-hot current lane grant (01 = lane 1, 10 = lane 2, 00 = idle).

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, GRANT1, GRANT2; grant SHALL decode directly from the state.
REQ-014 read_fX SHALL be high iff state = GRANTX, empty_fX = 0 and pause = 0; it is combinational from registered state and current inputs.
REQ-015 read_f1 and read_f2 SHALL never be high in the same cycle.
REQ-016 Lane pick from IDLE, or on leaving a grant: an almost-full non-empty lane wins; if both or neither are almost-full, the lane not served last wins (round-robin pointer); an empty lane is never picked.
REQ-017 IDLE -> GRANTX when at least one lane is non-empty, with X chosen by REQ-016; otherwise stay in IDLE.
REQ-018 GRANTX SHALL be left when: (a) empty_fX = 1; or (b) the burst count equals BURST_MAX and the other lane is non-empty; or (c) the other lane is almost-full and lane X is not.
REQ-019 On leaving GRANTX, go to the other GRANT state if the other lane is non-empty, else to IDLE.
REQ-020 The 3-bit burst counter SHALL increment on each read in the current grant, clear on every state change, and hold while pause = 1.
REQ-021 While pause = 1 the state and the round-robin pointer SHALL hold; REQ-018(c) is evaluated only while pause = 0.
REQ-022 The round-robin pointer SHALL update to lane X when GRANTX is exited.
REQ-023 Latency: a read in cycle N SHALL produce data_out = data_fX and valid_out = 1 in cycle N+2, via a registered read-valid/lane-select stage and a registered output stage.
REQ-024 Back-to-back reads SHALL give back-to-back valid_out with no bubbles; a grant switch adds no bubble when the next lane is non-empty.
REQ-025 write SHALL be registered: write <= !(almost_full_f1 | almost_full_f2).
REQ-026 data_out SHALL hold its last value while valid_out = 0.

Reset
REQ-027 While reset is high, the following SHALL be forced immediately and asynchronously: state = IDLE, pointer = lane 2 (lane 1 wins the first tie), burst count = 0, pipeline valid = 0, valid_out = 0, data_out = 8'h00, write = 0; read_f1 and read_f2 therefore read 0.
REQ-028 Reset mid-burst SHALL discard any byte in flight (no valid_out after reset release); the first read SHALL occur no earlier than the first edge after release.

Structure
REQ-029 Shared package disp_ctrl_pkg SHALL hold the state encodings (IDLE = 2'b00, GRANT1 = 2'b01, GRANT2 = 2'b10), the lane IDs and the BURST_MAX default.
REQ-030 The lane-pick logic of REQ-016 SHALL be a combinational sub-module, lane_pick, instantiated once.

Verification
REQ-031 Only lane 1 has data (5 bytes A0..A4), pause = 0 -> read_f1 high for 5 consecutive cycles, then GRANT1 -> IDLE; valid_out high 5 cycles starting 2 cycles after the first read, data A0..A4 in order.
REQ-032 Both lanes hold 8 bytes, no almost-full, BURST_MAX = 4 -> reads alternate 4 from lane 1, 4 from lane 2, repeating; read_f1 and read_f2 never overlap; valid_out is continuous for 16 cycles.
REQ-033 Lane 1 is granted and lane 2 almost_full rises mid-burst -> lane 2 is granted on the next edge even though the burst count < 4; write drops to 0 one cycle after almost_full rises.
REQ-034 pause held for 3 cycles during GRANT2 -> no reads for 3 cycles, grant and count held; draining resumes with the same lane on the cycle pause falls; no bytes lost or duplicated.
REQ-035 reset asserted one cycle after a read -> valid_out stays 0, outputs at reset values immediately; after release with both lanes non-empty, lane 1 is granted first.

Source files
------------

// File: rtl/disp_ctrl_pkg.sv
// Shared types for the two-lane FIFO drain arbiter: state encodings,
// lane identifiers and the default burst length.
package disp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT1 = 2'b01,
        GRANT2 = 2'b10
    } state_t;

    typedef enum logic {
        LANE1 = 1'b0,
        LANE2 = 1'b1
    } lane_t;

    localparam int BURST_MAX_DEF = 4;
    localparam int DATA_W        = 8;

endpackage

// File: rtl/disp2_arbiter_ctrl_if.sv
// Lane FIFO flags/data, downstream pause and drained output of the arbiter.
interface disp2_arbiter_ctrl_if;
    import disp_ctrl_pkg::*;

    logic              empty_f1, empty_f2;
    logic              almost_full_f1, almost_full_f2;
    logic [DATA_W-1:0] data_f1, data_f2;
    logic              pause;
    logic              read_f1, read_f2;
    logic              write;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [1:0]        grant;

    modport master (
        input  empty_f1, empty_f2, almost_full_f1, almost_full_f2,
               data_f1, data_f2, pause,
        output read_f1, read_f2, write, data_out, valid_out, grant
    );

    modport slave (
        output empty_f1, empty_f2, almost_full_f1, almost_full_f2,
               data_f1, data_f2, pause,
        input  read_f1, read_f2, write, data_out, valid_out, grant
    );

endinterface

// File: rtl/lane_pick.sv
// Chooses which lane to grant from IDLE: urgency (almost-full) first,
// otherwise the lane not served last; an empty lane is never chosen.
module lane_pick
    import disp_ctrl_pkg::*;
(
    input  logic  empty_f1,
    input  logic  empty_f2,
    input  logic  almost_full_f1,
    input  logic  almost_full_f2,
    input  lane_t last_lane,
    output logic  any_ready,
    output lane_t pick
);
    logic urg1, urg2;

    always_comb begin
        urg1      = !empty_f1 && almost_full_f1;
        urg2      = !empty_f2 && almost_full_f2;
        any_ready = !empty_f1 || !empty_f2;
        pick      = LANE1;
        if (urg1 != urg2)
            pick = urg1 ? LANE1 : LANE2;
        else if (empty_f1)
            pick = LANE2;
        else if (empty_f2)
            pick = LANE1;
        else
            pick = (last_lane == LANE1) ? LANE2 : LANE1;
    end

endmodule

// File: rtl/disp2_arbiter_ctrl.sv
// Two-lane FIFO drain arbiter with bounded bursts, almost-full preemption
// and a two-stage read-to-output pipeline.
module disp2_arbiter_ctrl
    import disp_ctrl_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    disp2_arbiter_ctrl_if.master bus
);
    localparam logic [2:0] BURST_LIM = 3'(BURST_MAX);

    state_t     state, state_nxt;
    lane_t      last_lane, last_nxt;
    lane_t      pick, sel_q;
    logic       any_ready;
    logic [2:0] burst, burst_nxt;
    logic       rd1, rd2;
    logic [1:0] vld_pipe;

    lane_pick u_pick (
        .empty_f1       (bus.empty_f1),
        .empty_f2       (bus.empty_f2),
        .almost_full_f1 (bus.almost_full_f1),
        .almost_full_f2 (bus.almost_full_f2),
        .last_lane      (last_lane),
        .any_ready      (any_ready),
        .pick           (pick)
    );

    always_comb begin
        rd1       = (state == GRANT1) && !bus.empty_f1 && !bus.pause;
        rd2       = (state == GRANT2) && !bus.empty_f2 && !bus.pause;
        state_nxt = state;
        last_nxt  = last_lane;
        // Count includes this cycle's read so the switch lands right after the last burst read.
        burst_nxt = burst;
        if ((rd1 || rd2) && burst != BURST_LIM)
            burst_nxt = burst + 3'd1;

        if (!bus.pause) begin
            case (state)
                IDLE: if (any_ready)
                    state_nxt = (pick == LANE1) ? GRANT1 : GRANT2;
                GRANT1: if (bus.empty_f1 ||
                            (burst_nxt == BURST_LIM && !bus.empty_f2) ||
                            (bus.almost_full_f2 && !bus.almost_full_f1)) begin
                    state_nxt = bus.empty_f2 ? IDLE : GRANT2;
                    last_nxt  = LANE1;
                end
                GRANT2: if (bus.empty_f2 ||
                            (burst_nxt == BURST_LIM && !bus.empty_f1) ||
                            (bus.almost_full_f1 && !bus.almost_full_f2)) begin
                    state_nxt = bus.empty_f1 ? IDLE : GRANT1;
                    last_nxt  = LANE2;
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (state_nxt != state)
            burst_nxt = 3'd0;

        bus.read_f1   = rd1;
        bus.read_f2   = rd2;
        bus.grant     = state;
        bus.valid_out = vld_pipe[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last_lane <= LANE2;
            burst     <= 3'd0;
        end else begin
            state     <= state_nxt;
            last_lane <= last_nxt;
            burst     <= burst_nxt;
        end
    end

    // Stage 1 remembers which lane was popped; stage 2 captures that lane's data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe     <= 2'b00;
            sel_q        <= LANE1;
            bus.data_out <= '0;
            bus.write    <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], rd1 || rd2};
            if (rd1 || rd2)
                sel_q <= rd2 ? LANE2 : LANE1;
            if (vld_pipe[0])
                bus.data_out <= (sel_q == LANE2) ? bus.data_f2 : bus.data_f1;
            bus.write <= !(bus.almost_full_f1 || bus.almost_full_f2);
        end
    end

endmodule

// File: tb/tb_disp2_arbiter_ctrl.sv
// Self-checking bench: FIFO models feed the arbiter, a scoreboard checks every
// drained byte and its arrival cycle, and per-scenario tasks check arbitration.
module tb_disp2_arbiter_ctrl;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    disp2_arbiter_ctrl_if bus ();

    disp2_arbiter_ctrl #(.BURST_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t       sb[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int         rd_log[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] last_exp = 8'h00;

    // Lane FIFOs: pop on strobe, data appears the next cycle, empty is registered.
    always @(posedge clk) begin : fifo_model
        logic [7:0] d;
        total++;
        if ((bus.read_f1 && bus.read_f2) || (bus.pause && (bus.read_f1 || bus.read_f2))) begin
            bad++;
            $display("FAIL read_strobes cyc=%0d got r1=%b r2=%b pause=%b exp=one_strobe_max_and_none_in_pause",
                     cyc, bus.read_f1, bus.read_f2, bus.pause);
        end
        if (bus.read_f1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL pop_empty_f1 cyc=%0d got=read exp=no_read", cyc);
            end else begin
                d = q1.pop_front();
                bus.data_f1 <= d;
                sb.push_back('{d, cyc + 2});
                rd_log.push_back(1);
            end
        end
        if (bus.read_f2) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL pop_empty_f2 cyc=%0d got=read exp=no_read", cyc);
            end else begin
                d = q2.pop_front();
                bus.data_f2 <= d;
                sb.push_back('{d, cyc + 2});
                rd_log.push_back(2);
            end
        end
        bus.empty_f1 <= (q1.size() == 0);
        bus.empty_f2 <= (q2.size() == 0);
        cyc++;
    end

    // Output monitor: every valid byte must match the scoreboard head, in its cycle.
    always @(negedge clk) begin : out_monitor
        exp_t e;
        if (reset) begin
            sb.delete();
            last_exp = 8'h00;
        end else if (bus.valid_out === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid cyc=%0d got data=%h exp=no_valid", cyc, bus.data_out);
            end else begin
                e = sb.pop_front();
                last_exp = e.d;
                if (bus.data_out !== e.d || cyc != e.c) begin
                    bad++;
                    $display("FAIL out_byte got data=%h cyc=%0d exp data=%h cyc=%0d",
                             bus.data_out, cyc, e.d, e.c);
                end
            end
        end else begin
            total++;
            if (bus.data_out !== last_exp) begin
                bad++;
                $display("FAIL data_hold cyc=%0d got=%h exp=%h", cyc, bus.data_out, last_exp);
            end
            if (sb.size() > 0) begin
                if (sb[0].c <= cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missing_byte cyc=%0d got=no_valid exp data=%h", cyc, sb[0].d);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic check_log(input string name, input int exp_seq[$]);
        total++;
        if (rd_log.size() != exp_seq.size()) begin
            bad++;
            $display("FAIL %s_len got=%0d exp=%0d", name, rd_log.size(), exp_seq.size());
        end else begin
            for (int i = 0; i < exp_seq.size(); i++) begin
                total++;
                if (rd_log[i] != exp_seq[i]) begin
                    bad++;
                    $display("FAIL %s_lane[%0d] got=%0d exp=%0d", name, i, rd_log[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        total++;
        if ({bus.grant, bus.read_f1, bus.read_f2, bus.valid_out, bus.write} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got grant=%b r1=%b r2=%b v=%b w=%b exp=all_zero",
                     bus.grant, bus.read_f1, bus.read_f2, bus.valid_out, bus.write);
        end
        total++;
        if (bus.data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_data got=%h exp=00", bus.data_out);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        total++;
        if (bus.write !== 1'b1 || bus.grant !== 2'b00) begin
            bad++;
            $display("FAIL post_reset got write=%b grant=%b exp write=1 grant=00", bus.write, bus.grant);
        end
    endtask

    task automatic test_single_lane;
        int k = -1, n1 = 0, n2 = 0, nv = 0;
        logic gap = 1'b0;
        logic [1:0] g_after = 2'bxx, g_idle = 2'bxx;
        rd_log.delete();
        for (int i = 0; i < 5; i++) q1.push_back(8'hA0 + 8'(i));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (bus.read_f1 && k < 0) k = c;
            if (bus.read_f1) n1++;
            if (bus.read_f2) n2++;
            if (bus.valid_out) nv++;
            if (k >= 0 && c < k + 5 && !bus.read_f1) gap = 1'b1;
            if (k >= 0 && c == k + 5) g_after = bus.grant;
            if (k >= 0 && c == k + 6) g_idle = bus.grant;
        end
        total++;
        if (k < 0 || n1 != 5 || n2 != 0 || gap) begin
            bad++;
            $display("FAIL single_reads got n1=%0d n2=%0d gap=%b start=%0d exp n1=5 n2=0 gap=0", n1, n2, gap, k);
        end
        total++;
        if (g_after !== 2'b01 || g_idle !== 2'b00) begin
            bad++;
            $display("FAIL single_grant got after=%b then=%b exp after=01 then=00", g_after, g_idle);
        end
        total++;
        if (nv != 5 || sb.size() != 0) begin
            bad++;
            $display("FAIL single_valid got valid_cycles=%0d pending=%0d exp 5 and 0", nv, sb.size());
        end
        check_log("single", '{1, 1, 1, 1, 1});
    endtask

    task automatic test_alternate;
        int run = 0, best = 0, nv = 0;
        rd_log.delete();
        for (int i = 0; i < 8; i++) begin
            q1.push_back(8'hB0 + 8'(i));
            q2.push_back(8'hC0 + 8'(i));
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (bus.valid_out) begin
                nv++;
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
        end
        // Lane 1 was served last, so lane 2 wins the opening tie.
        check_log("alternate", '{2, 2, 2, 2, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1});
        total++;
        if (nv != 16 || best != 16) begin
            bad++;
            $display("FAIL alternate_valid got total=%0d longest_run=%0d exp 16 and 16", nv, best);
        end
    endtask

    task automatic test_almost_full;
        int budget = 0;
        rd_log.delete();
        for (int i = 0; i < 8; i++) q1.push_back(8'hD0 + 8'(i));
        do begin
            @(negedge clk); #1;
            budget++;
        end while (!bus.read_f1 && budget < 20);
        total++;
        if (!bus.read_f1) begin
            bad++;
            $display("FAIL af_first_read got=timeout exp=read_f1");
        end
        for (int i = 0; i < 4; i++) q2.push_back(8'hE0 + 8'(i));
        @(negedge clk); #1;
        total++;
        if (bus.grant !== 2'b01 || bus.read_f1 !== 1'b1 || bus.write !== 1'b1) begin
            bad++;
            $display("FAIL af_before got grant=%b r1=%b write=%b exp 01 1 1", bus.grant, bus.read_f1, bus.write);
        end
        bus.almost_full_f2 = 1'b1;
        @(negedge clk); #1;
        total++;
        if (bus.grant !== 2'b10 || bus.read_f2 !== 1'b1 || bus.write !== 1'b0) begin
            bad++;
            $display("FAIL af_preempt got grant=%b r2=%b write=%b exp 10 1 0", bus.grant, bus.read_f2, bus.write);
        end
        bus.almost_full_f2 = 1'b0;
        repeat (30) @(negedge clk);
        check_log("almost_full", '{1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 1, 1});
        total++;
        if (bus.write !== 1'b1 || bus.grant !== 2'b00) begin
            bad++;
            $display("FAIL af_after got write=%b grant=%b exp 1 00", bus.write, bus.grant);
        end
    endtask

    task automatic test_pause;
        int budget = 0;
        rd_log.delete();
        for (int i = 0; i < 3; i++) q1.push_back(8'hF0 + 8'(i));
        for (int i = 0; i < 6; i++) q2.push_back(8'h60 + 8'(i));
        do begin
            @(negedge clk);
            budget++;
        end while (rd_log.size() < 2 && budget < 20);
        bus.pause = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            total++;
            if (bus.read_f1 || bus.read_f2 || bus.grant !== 2'b10 || rd_log.size() != 2) begin
                bad++;
                $display("FAIL pause_hold[%0d] got r1=%b r2=%b grant=%b reads=%0d exp 0 0 10 2",
                         c, bus.read_f1, bus.read_f2, bus.grant, rd_log.size());
            end
        end
        @(negedge clk);
        bus.pause = 1'b0;
        #1;
        total++;
        if (bus.read_f2 !== 1'b1 || bus.grant !== 2'b10) begin
            bad++;
            $display("FAIL pause_resume got r2=%b grant=%b exp 1 10", bus.read_f2, bus.grant);
        end
        repeat (30) @(negedge clk);
        // Held count means lane 2 still yields after its 4th read overall.
        check_log("pause", '{2, 2, 2, 2, 1, 1, 1, 2, 2});
    endtask

    task automatic test_reset_midburst;
        int budget = 0;
        q1.push_back(8'h70);
        q1.push_back(8'h71);
        repeat (12) @(negedge clk);
        rd_log.delete();
        for (int i = 0; i < 4; i++) begin
            q1.push_back(8'h80 + 8'(i));
            q2.push_back(8'h90 + 8'(i));
        end
        do begin
            @(negedge clk);
            budget++;
        end while (rd_log.size() < 1 && budget < 20);
        total++;
        if (rd_log.size() < 1 || rd_log[0] != 2) begin
            bad++;
            $display("FAIL rst_pre_lane got=%0d exp=2", rd_log.size() ? rd_log[0] : 0);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({bus.grant, bus.read_f1, bus.read_f2, bus.valid_out, bus.write} !== 6'b0 || bus.data_out !== 8'h00) begin
            bad++;
            $display("FAIL rst_async got grant=%b r1=%b r2=%b v=%b w=%b d=%h exp all zero",
                     bus.grant, bus.read_f1, bus.read_f2, bus.valid_out, bus.write, bus.data_out);
        end
        repeat (2) begin
            @(negedge clk); #1;
            total++;
            if (bus.valid_out !== 1'b0) begin
                bad++;
                $display("FAIL rst_valid got=%b exp=0", bus.valid_out);
            end
        end
        rd_log.delete();
        reset = 1'b0;
        #1;
        total++;
        if (bus.read_f1 || bus.read_f2) begin
            bad++;
            $display("FAIL rst_release_read got r1=%b r2=%b exp 0 0", bus.read_f1, bus.read_f2);
        end
        repeat (30) @(negedge clk);
        check_log("rst_after", '{1, 1, 1, 1, 2, 2, 2});
    endtask

    initial begin
        bus.almost_full_f1 = 1'b0;
        bus.almost_full_f2 = 1'b0;
        bus.pause          = 1'b0;
        #1 reset = 1'b1;
        test_reset();
        test_single_lane();
        test_alternate();
        test_almost_full();
        test_pause();
        test_reset_midburst();
        repeat (4) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL final_drain got pending=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
